// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the single-port RAM.
interface ram_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic [DATA_W-1:0] m1_rdata;

  logic              ramCe;
  logic              ramWe;
  logic [ADDR_W-1:0] ramAddr;
  logic [DATA_W-1:0] ramWtData;
  logic [DATA_W-1:0] ramRdData;

  logic              owner;
  logic              busy;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_gnt, m1_rdata,
    output ramCe, ramWe, ramAddr, ramWtData,
    input  ramRdData,
    output owner, busy
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_gnt, m1_rdata,
    input  ramCe, ramWe, ramAddr, ramWtData,
    output ramRdData,
    input  owner, busy
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-master arbiter for a single-port RAM: IDLE -> ACC -> RESP per access,
// round-robin or fixed (m0-first) priority.
module ram_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int FIXED_PRI = 0
) (
  input  logic          clk,
  input  logic          rst,
  ram_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;

  state_t            state, state_nxt;
  logic              owner_q;
  logic              last_win;
  logic [DATA_W-1:0] rdata_q;
  logic              any_req;
  logic              winner;
  logic              sel_we;

  assign any_req = bus.m0_req | bus.m1_req;

  always_comb begin
    winner = 1'b0;
    if (FIXED_PRI != 0)
      winner = ~bus.m0_req;
    else if (bus.m0_req && bus.m1_req)
      winner = ~last_win;
    else
      winner = bus.m1_req;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req) state_nxt = ACC;
      ACC:     state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      owner_q  <= 1'b0;
      last_win <= 1'b1;
      rdata_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_req)
        owner_q <= winner;
      if (state == ACC) begin
        rdata_q  <= bus.ramRdData;
        last_win <= owner_q;
      end
    end
  end

  assign sel_we = owner_q ? bus.m1_we : bus.m0_we;

  always_comb begin
    bus.ramCe     = (state == ACC);
    // A reset edge landing on ACC must not commit the write.
    bus.ramWe     = (state == ACC) && sel_we && rst;
    bus.ramAddr   = owner_q ? bus.m1_addr  : bus.m0_addr;
    bus.ramWtData = owner_q ? bus.m1_wdata : bus.m0_wdata;
    bus.m0_gnt    = (state == RESP) && !owner_q;
    bus.m1_gnt    = (state == RESP) &&  owner_q;
    bus.m0_rdata  = bus.m0_gnt ? rdata_q : '0;
    bus.m1_rdata  = bus.m1_gnt ? rdata_q : '0;
    bus.owner     = owner_q;
    bus.busy      = (state == ACC) || (state == RESP);
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench: round-robin and fixed-priority arbiters, each with a small RAM model.
module tb_ram_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   tests  = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  ram_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus_rr ();
  ram_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus_fp ();

  ram_arbiter #(.DATA_W(32), .ADDR_W(32), .FIXED_PRI(0)) u_rr (
    .clk(clk), .rst(rst), .bus(bus_rr.slave));
  ram_arbiter #(.DATA_W(32), .ADDR_W(32), .FIXED_PRI(1)) u_fp (
    .clk(clk), .rst(rst), .bus(bus_fp.slave));

  logic [31:0] mem_rr [256];
  logic [31:0] mem_fp [256];

  assign bus_rr.ramRdData = bus_rr.ramCe ? mem_rr[bus_rr.ramAddr[7:0]] : 32'h0;
  assign bus_fp.ramRdData = bus_fp.ramCe ? mem_fp[bus_fp.ramAddr[7:0]] : 32'h0;

  always @(posedge clk) begin
    if (bus_rr.ramCe && bus_rr.ramWe) mem_rr[bus_rr.ramAddr[7:0]] <= bus_rr.ramWtData;
    if (bus_fp.ramCe && bus_fp.ramWe) mem_fp[bus_fp.ramAddr[7:0]] <= bus_fp.ramWtData;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_rr[i] = 32'h0;
      mem_fp[i] = 32'h0;
    end
    mem_rr[8'h20] = 32'h2020_2020;
    mem_rr[8'h30] = 32'h3030_3030;
    mem_rr[8'h40] = 32'h4040_4040;
    mem_fp[8'h30] = 32'h3030_3030;
    mem_fp[8'h40] = 32'h4040_4040;

    rst = 1'b0;
    bus_rr.m0_req = 0; bus_rr.m0_we = 0; bus_rr.m0_addr = 0; bus_rr.m0_wdata = 0;
    bus_rr.m1_req = 0; bus_rr.m1_we = 0; bus_rr.m1_addr = 0; bus_rr.m1_wdata = 0;
    bus_fp.m0_req = 0; bus_fp.m0_we = 0; bus_fp.m0_addr = 0; bus_fp.m0_wdata = 0;
    bus_fp.m1_req = 0; bus_fp.m1_we = 0; bus_fp.m1_addr = 0; bus_fp.m1_wdata = 0;
    step(); step();

    // Reset state
    check("rst_m0_gnt", bus_rr.m0_gnt, 0);
    check("rst_m1_gnt", bus_rr.m1_gnt, 0);
    check("rst_m0_rdata", bus_rr.m0_rdata, 0);
    check("rst_ramCe", bus_rr.ramCe, 0);
    check("rst_ramWe", bus_rr.ramWe, 0);
    check("rst_busy", bus_rr.busy, 0);
    check("rst_owner", bus_rr.owner, 0);
    check("rst_fp_busy", bus_fp.busy, 0);
    rst = 1'b1;

    // Single write then read by m0
    bus_rr.m0_req = 1; bus_rr.m0_we = 1; bus_rr.m0_addr = 32'h10; bus_rr.m0_wdata = 32'hDEADBEEF;
    step();
    check("wr_acc_busy", bus_rr.busy, 1);
    check("wr_acc_ce", bus_rr.ramCe, 1);
    check("wr_acc_we", bus_rr.ramWe, 1);
    check("wr_acc_addr", bus_rr.ramAddr, 32'h10);
    check("wr_acc_wdata", bus_rr.ramWtData, 32'hDEADBEEF);
    check("wr_acc_m0_gnt", bus_rr.m0_gnt, 0);
    step();
    check("wr_resp_gnt", bus_rr.m0_gnt, 1);
    check("wr_resp_rdata_prewrite", bus_rr.m0_rdata, 0);
    check("wr_resp_ce", bus_rr.ramCe, 0);
    check("wr_resp_we", bus_rr.ramWe, 0);
    check("wr_resp_busy", bus_rr.busy, 1);
    bus_rr.m0_req = 0;
    step();
    check("wr_idle_gnt", bus_rr.m0_gnt, 0);
    check("wr_idle_busy", bus_rr.busy, 0);
    check("wr_committed", mem_rr[8'h10], 32'hDEADBEEF);
    bus_rr.m0_req = 1; bus_rr.m0_we = 0; bus_rr.m0_addr = 32'h10;
    step();
    check("rd_acc_we", bus_rr.ramWe, 0);
    check("rd_acc_ce", bus_rr.ramCe, 1);
    step();
    check("rd_resp_gnt", bus_rr.m0_gnt, 1);
    check("rd_resp_rdata", bus_rr.m0_rdata, 32'hDEADBEEF);
    bus_rr.m0_req = 0;
    step();
    check("rd_idle_rdata", bus_rr.m0_rdata, 0);

    // Round-robin tie after reset: m0 first, then alternate
    rst = 1'b0; step(); rst = 1'b1;
    bus_rr.m0_req = 1; bus_rr.m0_we = 0; bus_rr.m0_addr = 32'h30;
    bus_rr.m1_req = 1; bus_rr.m1_we = 0; bus_rr.m1_addr = 32'h40;
    step();
    check("rr1_owner", bus_rr.owner, 0);
    check("rr1_addr", bus_rr.ramAddr, 32'h30);
    step();
    check("rr1_m0_gnt", bus_rr.m0_gnt, 1);
    check("rr1_m0_rdata", bus_rr.m0_rdata, 32'h3030_3030);
    check("rr1_m1_gnt", bus_rr.m1_gnt, 0);
    check("rr1_m1_rdata", bus_rr.m1_rdata, 0);
    step();
    check("rr_idle_busy", bus_rr.busy, 0);
    check("rr_idle_owner_hold", bus_rr.owner, 0);
    step();
    check("rr2_owner", bus_rr.owner, 1);
    check("rr2_addr", bus_rr.ramAddr, 32'h40);
    step();
    check("rr2_m1_gnt", bus_rr.m1_gnt, 1);
    check("rr2_m1_rdata", bus_rr.m1_rdata, 32'h4040_4040);
    check("rr2_m0_gnt", bus_rr.m0_gnt, 0);
    step(); step();
    check("rr3_owner", bus_rr.owner, 0);
    step();
    check("rr3_m0_gnt", bus_rr.m0_gnt, 1);
    bus_rr.m0_req = 0; bus_rr.m1_req = 0;
    step();
    check("rr3_idle_owner", bus_rr.owner, 0);

    // Reset during m1 write ACC aborts the access
    bus_rr.m1_req = 1; bus_rr.m1_we = 1; bus_rr.m1_addr = 32'h20; bus_rr.m1_wdata = 32'h12345678;
    step();
    check("abort_acc_owner", bus_rr.owner, 1);
    check("abort_acc_we", bus_rr.ramWe, 1);
    rst = 1'b0;
    #1;
    check("abort_we_forced", bus_rr.ramWe, 0);
    bus_rr.m1_req = 0;
    step();
    rst = 1'b1;
    check("abort_m1_gnt", bus_rr.m1_gnt, 0);
    check("abort_m1_rdata", bus_rr.m1_rdata, 0);
    check("abort_busy", bus_rr.busy, 0);
    check("abort_ce", bus_rr.ramCe, 0);
    check("abort_owner", bus_rr.owner, 0);
    check("abort_mem", mem_rr[8'h20], 32'h2020_2020);
    step();
    check("abort_no_late_gnt", bus_rr.m1_gnt, 0);

    // m0 request arriving in m1 RESP waits for IDLE
    bus_rr.m1_req = 1; bus_rr.m1_we = 0; bus_rr.m1_addr = 32'h40;
    step(); step();
    check("late_m1_gnt", bus_rr.m1_gnt, 1);
    check("late_resp_ce", bus_rr.ramCe, 0);
    bus_rr.m1_req = 0;
    bus_rr.m0_req = 1; bus_rr.m0_we = 0; bus_rr.m0_addr = 32'h30;
    step();
    check("late_idle_busy", bus_rr.busy, 0);
    check("late_idle_ce", bus_rr.ramCe, 0);
    step();
    check("late_acc_owner", bus_rr.owner, 0);
    check("late_acc_ce", bus_rr.ramCe, 1);
    step();
    check("late_m0_gnt", bus_rr.m0_gnt, 1);
    check("late_m0_rdata", bus_rr.m0_rdata, 32'h3030_3030);
    check("late_m0_resp_ce", bus_rr.ramCe, 0);
    bus_rr.m0_req = 0;
    step();

    // Fixed priority: m0 keeps winning while it holds req
    bus_fp.m0_req = 1; bus_fp.m0_we = 0; bus_fp.m0_addr = 32'h30;
    bus_fp.m1_req = 1; bus_fp.m1_we = 0; bus_fp.m1_addr = 32'h40;
    for (int r = 0; r < 3; r++) begin
      step();
      check("fp_acc_owner", bus_fp.owner, 0);
      step();
      check("fp_m0_gnt", bus_fp.m0_gnt, 1);
      check("fp_m1_gnt", bus_fp.m1_gnt, 0);
      if (r == 2) bus_fp.m0_req = 0;
      step();
    end
    step();
    check("fp_m1_owner", bus_fp.owner, 1);
    step();
    check("fp_m1_gnt_after_drop", bus_fp.m1_gnt, 1);
    check("fp_m1_rdata", bus_fp.m1_rdata, 32'h4040_4040);
    bus_fp.m1_req = 0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
